// File: rtl/spi_master_engine_pkg.sv
// Shared definitions for the co-processor SPI engine: FSM state encoding and
// the fixed slave channel assignment on the co-processor bus.
package spi_master_engine_pkg;

    typedef enum logic [5:0] {
        ST_IDLE      = 6'b000001,
        ST_SEND      = 6'b000010,
        ST_SENDING   = 6'b000100,
        ST_RECEIVE   = 6'b001000,
        ST_RECEIVING = 6'b010000,
        ST_DONE      = 6'b100000
    } spi_state_t;

    localparam int SLAVE_ALU = 0;
    localparam int SLAVE_BAS = 1;
    localparam int SLAVE_MUL = 2;

endpackage

// File: rtl/spi_shift_counter.sv
// Clearable up-counter with a terminal-count flag; used for both the bit
// position and the handshake wait budget of the SPI engine.
module spi_shift_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             last
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == terminal);

endmodule

// File: rtl/spi_master_engine.sv
// Reusable SPI request engine: handshake with the selected slave, shift the
// request out LSB first, wait for the reply start and shift RX_WIDTH bits in.
module spi_master_engine
    import spi_master_engine_pkg::*;
#(
    parameter  int NUM_SLAVES     = 3,
    parameter  int TX_WIDTH       = 20,
    parameter  int RX_WIDTH       = 8,
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int SEL_W          = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
    localparam int LEN_W          = $clog2(TX_WIDTH + 1)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [SEL_W-1:0]      i_select,
    input  logic [LEN_W-1:0]      i_tx_len,
    input  logic [TX_WIDTH-1:0]   i_tx_data,
    output logic                  o_ready,
    output logic                  o_done,
    output logic                  o_error,
    output logic [RX_WIDTH-1:0]   o_rx_data,
    output logic                  o_sclk,
    output logic [NUM_SLAVES-1:0] o_nss,
    output logic                  o_mosi,
    input  logic                  i_miso
);

    localparam int BIT_W  = $clog2(((TX_WIDTH > RX_WIDTH) ? TX_WIDTH : RX_WIDTH) + 1);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    spi_state_t          state;
    logic [LEN_W-1:0]    len_q;
    logic [TX_WIDTH-1:0] tx_shift;
    logic [RX_WIDTH-1:0] rx_shift;
    logic                request_ok;

    logic [BIT_W-1:0]    bit_term;
    logic                bit_en, bit_clr, bit_last;
    logic                wait_en, wait_clr, wait_last;

    assign request_ok = (32'(i_select) < NUM_SLAVES) && (i_tx_len != '0) &&
                        (32'(i_tx_len) <= TX_WIDTH);

    assign bit_en   = (state == ST_SENDING) || (state == ST_RECEIVING);
    assign bit_clr  = !bit_en || bit_last;
    assign bit_term = (state == ST_SENDING) ? BIT_W'(len_q - 1'b1) : BIT_W'(RX_WIDTH - 1);

    // Wait budget only runs while a handshake is outstanding; any ack restarts it.
    assign wait_en  = ((state == ST_SEND) && i_miso) || ((state == ST_RECEIVE) && !i_miso);
    assign wait_clr = !wait_en;

    spi_shift_counter #(.WIDTH(BIT_W)) u_bit_counter (
        .clk      (i_clock),
        .rst_n    (i_reset),
        .clear    (bit_clr),
        .enable   (bit_en),
        .terminal (bit_term),
        .last     (bit_last)
    );

    spi_shift_counter #(.WIDTH(WAIT_W)) u_wait_counter (
        .clk      (i_clock),
        .rst_n    (i_reset),
        .clear    (wait_clr),
        .enable   (wait_en),
        .terminal (WAIT_W'(TIMEOUT_CYCLES - 1)),
        .last     (wait_last)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            o_nss     <= '1;
            o_mosi    <= 1'b0;
            o_done    <= 1'b0;
            o_error   <= 1'b0;
            o_rx_data <= '0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        len_q    <= i_tx_len;
                        tx_shift <= i_tx_data;
                        if (request_ok) begin
                            state  <= ST_SEND;
                            o_nss  <= ~(NUM_SLAVES'(1) << i_select);
                            o_mosi <= 1'b1;
                        end else begin
                            state     <= ST_DONE;
                            o_done    <= 1'b1;
                            o_error   <= 1'b1;
                            o_rx_data <= '0;
                        end
                    end
                end
                ST_SEND: begin
                    if (!i_miso) begin
                        state  <= ST_SENDING;
                        o_mosi <= tx_shift[0];
                    end else if (wait_last) begin
                        state     <= ST_DONE;
                        o_done    <= 1'b1;
                        o_error   <= 1'b1;
                        o_rx_data <= '0;
                        o_nss     <= '1;
                        o_mosi    <= 1'b0;
                    end
                end
                ST_SENDING: begin
                    // mosi is registered, so it is loaded one bit ahead of the shifter.
                    tx_shift <= tx_shift >> 1;
                    if (bit_last) begin
                        state  <= ST_RECEIVE;
                        o_mosi <= 1'b0;
                    end else begin
                        o_mosi <= tx_shift[1];
                    end
                end
                ST_RECEIVE: begin
                    if (i_miso) begin
                        state <= ST_RECEIVING;
                    end else if (wait_last) begin
                        state     <= ST_DONE;
                        o_done    <= 1'b1;
                        o_error   <= 1'b1;
                        o_rx_data <= '0;
                        o_nss     <= '1;
                    end
                end
                ST_RECEIVING: begin
                    rx_shift <= {i_miso, rx_shift[RX_WIDTH-1:1]};
                    if (bit_last) begin
                        state     <= ST_DONE;
                        o_done    <= 1'b1;
                        o_error   <= 1'b0;
                        o_rx_data <= {i_miso, rx_shift[RX_WIDTH-1:1]};
                        o_nss     <= '1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    o_nss  <= '1;
                    o_mosi <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = (state == ST_IDLE);
    assign o_sclk  = i_clock;

endmodule

// File: tb/tb_spi_master_engine.sv
// Bench for spi_master_engine: a scripted slave plus a cycle-schedule model of
// each request (handshake, shift-out, reply start, shift-in, done).
module tb_spi_master_engine;
    import spi_master_engine_pkg::*;

    localparam int NS  = 3;
    localparam int TXW = 20;
    localparam int RXW = 8;
    localparam int TO  = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  select;
    logic [4:0]  tx_len;
    logic [19:0] tx_data;
    logic        ready, done, error, sclk, mosi, miso;
    logic [7:0]  rx_data;
    logic [2:0]  nss;

    int checks   = 0;
    int failures = 0;

    spi_master_engine #(
        .NUM_SLAVES(NS), .TX_WIDTH(TXW), .RX_WIDTH(RXW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_start   (start),
        .i_select  (select),
        .i_tx_len  (tx_len),
        .i_tx_data (tx_data),
        .o_ready   (ready),
        .o_done    (done),
        .o_error   (error),
        .o_rx_data (rx_data),
        .o_sclk    (sclk),
        .o_nss     (nss),
        .o_mosi    (mosi),
        .i_miso    (miso)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the engine idle. Cycle c is the c-th clock period
    // after the accepting edge; outputs are sampled mid-cycle, miso is then set
    // for the edge that closes cycle c. da/dr: extra wait cycles before the slave
    // acks / starts replying (>= TO means never).
    task automatic do_txn(input int sel, input int len, input logic [19:0] data,
                          input int da, input int dr, input logic [7:0] rxv,
                          input int pulse_c, input int abort_c);
        bit         valid, send_to, recv_to, exp_err;
        int         done_c, r0, s;
        logic [7:0] exp_rx;
        logic [2:0] one, exp_nss;
        logic       exp_mosi, m;
        valid   = (sel < NS) && (len >= 1) && (len <= TXW);
        send_to = (da >= TO);
        recv_to = (dr >= TO);
        r0      = da + len + 2;
        s       = r0 + dr;
        exp_rx  = 8'h00;
        exp_err = 1'b1;
        if (!valid)       done_c = 1;
        else if (send_to) done_c = TO + 1;
        else if (recv_to) done_c = r0 + TO;
        else begin
            done_c  = s + RXW + 1;
            exp_rx  = rxv;
            exp_err = 1'b0;
        end
        one     = 3'b001;
        start   = 1'b1;
        select  = sel[1:0];
        tx_len  = len[4:0];
        tx_data = data;
        miso    = 1'b1;
        @(posedge clock);
        for (int c = 1; c <= done_c + 1; c++) begin
            @(negedge clock);
            start = (c == pulse_c);
            exp_nss  = (valid && c < done_c) ? ~(one << sel) : 3'b111;
            exp_mosi = 1'b0;
            if (valid && c < done_c && c <= da + 1) exp_mosi = 1'b1;
            else if (valid && !send_to && c >= da + 2 && c <= da + 1 + len) exp_mosi = data[c - da - 2];
            check($sformatf("nss c%0d", c), 32'(nss), 32'(exp_nss));
            check($sformatf("mosi c%0d", c), 32'(mosi), 32'(exp_mosi));
            check($sformatf("done c%0d", c), 32'(done), 32'(c == done_c));
            check($sformatf("ready c%0d", c), 32'(ready), 32'(c > done_c));
            if (c == done_c) begin
                check("error", 32'(error), 32'(exp_err));
                check("rx_data", 32'(rx_data), 32'(exp_rx));
            end
            if (c == abort_c) begin
                reset = 1'b0;
                #1;
                check("abort nss", 32'(nss), 32'h7);
                check("abort mosi", 32'(mosi), 32'h0);
                check("abort done", 32'(done), 32'h0);
                check("abort error", 32'(error), 32'h0);
                check("abort rx", 32'(rx_data), 32'h0);
                check("abort ready", 32'(ready), 32'h1);
                @(negedge clock);
                reset = 1'b1;
                return;
            end
            if (c <= da)                   m = 1'b1;
            else if (c <= da + 1 + len)    m = 1'b0;
            else if (c < s)                m = 1'b0;
            else if (c == s)               m = 1'b1;
            else if (c <= s + RXW)         m = rxv[c - s - 1];
            else                           m = 1'b1;
            miso = m;
        end
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        miso    = 1'b1;
        select  = '0;
        tx_len  = '0;
        tx_data = '0;
        repeat (2) @(negedge clock);
        check("rst ready", 32'(ready), 32'h1);
        check("rst nss", 32'(nss), 32'h7);
        check("rst mosi", 32'(mosi), 32'h0);
        check("rst done", 32'(done), 32'h0);
        check("rst error", 32'(error), 32'h0);
        check("rst rx", 32'(rx_data), 32'h0);
        check("sclk", 32'(sclk), 32'(clock));
        reset = 1'b1;
        @(negedge clock);

        do_txn(SLAVE_ALU, 20, 20'h5A3C2, 0, 0, 8'h7E, 0, 0);
        do_txn(SLAVE_MUL, 16, 20'h00305, 5, 3, 8'h0F, 0, 0);
        do_txn(1, 8, 20'h000AB, 1000, 0, 8'h55, 0, 0);
        do_txn(0, 4, 20'h00009, 0, 1000, 8'h55, 0, 0);
        do_txn(3, 8, 20'h00011, 0, 0, 8'h66, 0, 0);
        do_txn(1, 0, 20'h00011, 0, 0, 8'h66, 0, 0);
        do_txn(0, 21, 20'h00011, 0, 0, 8'h66, 0, 0);
        do_txn(1, 12, 20'h00C35, 2, 1, 8'hA5, 6, 0);
        do_txn(2, 10, 20'h002B1, 1, 2, 8'h3C, 0, 18);
        do_txn(2, 1, 20'h00001, 0, 0, 8'hC3, 0, 0);
        do_txn(0, 20, 20'hFFFFF, 63, 63, 8'h81, 0, 0);

        for (int i = 0; i < 10; i++) begin
            do_txn(int'($urandom_range(0, 2)), int'($urandom_range(1, TXW)),
                   20'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                   8'($urandom), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_master_engine.md
Name: spi_master_engine

Overview:
- Generalised SPI transaction engine for the serial processor's co-processor bus (ALU, barrel shifter, multiplier and future units).
- Replaces the fixed, per-unit SPI sequencing inside the processor FSM with one reusable block.
- Supports N slave channels, a per-request transmit length, a parametrised receive width, and a timeout/error path.
- The processor's EXECUTE stage issues one request and waits for o_done.

Parameters:
- NUM_SLAVES, 3: number of nss lines / slave channels.
- TX_WIDTH, 20: maximum transmit packet bits; i_tx_data width.
- RX_WIDTH, 8: receive packet bits; o_rx_data width.
- TIMEOUT_CYCLES, 64: maximum cycles waited for a slave handshake in SEND or RECEIVE.

Ports:
- i_clock  in  1  system clock; also drives sclk.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  request strobe; sampled only while o_ready=1.
- i_select  in  $clog2(NUM_SLAVES) (min 1)  target slave index.
- i_tx_len  in  $clog2(TX_WIDTH+1)  number of bits to send, 1..TX_WIDTH.
- i_tx_data  in  TX_WIDTH  packet to send, LSB first.
- o_ready  out  1  engine idle; high exactly in IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_error  out  1  valid with o_done: 1 = timeout or invalid request.
- o_rx_data  out  RX_WIDTH  received packet, LSB first; held until the next accepted request.
- o_sclk  out  1  equals i_clock.
- o_nss  out  NUM_SLAVES  active-low selects.
- o_mosi  out  1  serial out.
- i_miso  in  1  serial in, shared by all slaves.

Behaviour:
- Reset: asynchronous on i_reset=0.
  - State IDLE, o_nss all ones, o_mosi=0, o_done=0, o_error=0, o_rx_data=0.
  - All counters and latched request fields are cleared.
  - Reset mid-transfer deasserts nss immediately, with no done pulse.
- State encoding: one-hot states IDLE, SEND, SENDING, RECEIVE, RECEIVING, DONE.
- Accept: on a rising edge with state=IDLE and i_start=1, latch select, tx_len and tx_data.
  - Valid request → SEND.
  - Invalid request (select ≥ NUM_SLAVES, tx_len=0 or tx_len>TX_WIDTH) → DONE with error set, and no nss asserted.
  - i_start outside IDLE is ignored; there is no queue.
- nss: o_nss[sel]=0 only in SEND, SENDING, RECEIVE and RECEIVING; all other bits are always 1.
- SEND: o_mosi=1.
  - i_miso=0 at an edge → SENDING.
  - Otherwise increment the wait counter; on reaching TIMEOUT_CYCLES → DONE with error.
- SENDING: o_mosi = tx_data[bit_cnt], with bit_cnt running 0..tx_len-1.
  - After bit tx_len-1 → RECEIVE, and bit_cnt clears.
- RECEIVE: o_mosi=0.
  - i_miso=1 at an edge → RECEIVING, and the wait counter clears.
  - Timeout handling is the same as in SEND.
- RECEIVING: on each edge, capture i_miso into rx_shift[bit_cnt] for bit_cnt 0..RX_WIDTH-1.
  - After bit RX_WIDTH-1 → DONE.
- DONE: lasts one cycle, then → IDLE.
  - o_done=1 during the DONE cycle.
  - On success, o_rx_data is updated from rx_shift at entry to DONE and o_error=0.
  - On error, o_rx_data=0 and o_error=1.
- o_mosi=0 in all states other than SEND and SENDING.
- Latency with immediate slave acks: o_done is high tx_len+RX_WIDTH+3 cycles after the accepting edge.
  - Each extra handshake wait cycle adds 1.
- Counters are saturating-free; widths are sized so tx_len=TX_WIDTH and TIMEOUT_CYCLES never wrap.

Decomposition:
- Shared package (Isa or a new SpiPkg): spi_state_t enum, and the slave index constants ALU/BAS/MUL = 0/1/2.
- Natural sub-module: spi_shift_counter, a loadable bit counter with terminal-count flag, instanced for the bit and wait counters.
- The processor replaces its inline SPI FSM with one instance of spi_master_engine.

Test Plan:
- ALU-style request: select=0, tx_len=20, tx_data=0x5A3C2, slave acks immediately and returns 0x7E → MOSI bits match LSB-first; nss=3'b110 only during the transfer; o_done 31 cycles after accept; o_rx_data=0x7E, o_error=0.
- Multiplier-style request: select=2, tx_len=16, tx_data=0x0305, slave delays the ack 5 cycles and the return start 3 cycles, returns 0x0F → done at 16+8+3+8=35 cycles; rx=0x0F.
- Send timeout: slave holds miso=1 during SEND → after 64 cycles o_done=1, o_error=1, rx=0, nss returns to all ones.
- Invalid requests: select=3 or tx_len=0 → o_done/o_error one cycle later; nss never leaves all ones.
- i_start pulsed during SENDING → ignored, current transfer unaffected; o_ready=0 until after DONE.
- Reset asserted in RECEIVING → nss all ones and outputs zero immediately; a new request after release completes normally.
